// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 port driver: widths, command and
// response codes, and the driver state encoding.
package calc1_pkg;

  localparam int DATA_W = 32;
  localparam int CMD_W  = 4;
  localparam int RESP_W = 2;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;
  localparam logic [1:0] RESP_IERR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE1 = 3'd1,
    ST_ISSUE2 = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

endpackage

// File: rtl/calc1_wait_timer.sv
// Saturating wait timer. done is high during the TIMEOUT_CYC-th enabled
// cycle after a clear, so the driver leaves WAIT on exactly that edge.
module calc1_wait_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] count_r;

  // Count enabled cycles since the last clear, holding at CNT_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign done = enable && (count_r >= CNT_LAST);

endmodule

// File: rtl/calc1_port_driver.sv
// Upstream request driver for one calc1 port: takes a whole operation,
// serialises it into the two-cycle calc1 request, waits for the response
// (or a timeout) and presents the result on a valid/ready interface.
module calc1_port_driver
  import calc1_pkg::*;
#(
  parameter int DATA_W      = calc1_pkg::DATA_W,
  parameter int CMD_W       = calc1_pkg::CMD_W,
  parameter int RESP_W      = calc1_pkg::RESP_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [CMD_W-1:0]  op_cmd,
  input  logic [DATA_W-1:0] op_data1,
  input  logic [DATA_W-1:0] op_data2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RESP_W-1:0] rsp_code,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic [CMD_W-1:0]  req_cmd_out,
  output logic [DATA_W-1:0] req_data_out,
  input  logic [RESP_W-1:0] out_resp,
  input  logic [DATA_W-1:0] out_data,
  output logic              spurious
);

  state_e              state_r;
  logic                op_ready_r;
  logic                rsp_valid_r;
  logic [RESP_W-1:0]   rsp_code_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                rsp_timeout_r;
  logic [CMD_W-1:0]    req_cmd_r;
  logic [DATA_W-1:0]   req_data_r;
  logic [DATA_W-1:0]   data2_r;
  logic                spurious_r;
  logic                timer_clear_s;
  logic                timer_enable_s;
  logic                timer_done_s;
  logic                resp_seen_s;

  assign timer_clear_s  = (state_r == ST_ISSUE2);
  assign timer_enable_s = (state_r == ST_WAIT);
  assign resp_seen_s    = (out_resp != '0);

  calc1_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk    (c_clk),
    .rst_n  (reset_n),
    .clear  (timer_clear_s),
    .enable (timer_enable_s),
    .done   (timer_done_s)
  );

  // Operation sequencer; every output is set on the edge that enters a state.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      op_ready_r    <= 1'b1;
      rsp_valid_r   <= 1'b0;
      rsp_code_r    <= '0;
      rsp_data_r    <= '0;
      rsp_timeout_r <= 1'b0;
      req_cmd_r     <= '0;
      req_data_r    <= '0;
      data2_r       <= '0;
      spurious_r    <= 1'b0;
    end else begin
      // A response outside WAIT is dropped but remembered until reset.
      if (resp_seen_s && (state_r != ST_WAIT)) begin
        spurious_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (op_valid) begin
            op_ready_r <= 1'b0;
            if (op_cmd != '0) begin
              req_cmd_r  <= op_cmd;
              req_data_r <= op_data1;
              data2_r    <= op_data2;
              state_r    <= ST_ISSUE1;
            end else begin
              // NOP is rejected locally; calc1 never sees it.
              rsp_valid_r   <= 1'b1;
              rsp_code_r    <= RESP_W'(RESP_ERR);
              rsp_data_r    <= '0;
              rsp_timeout_r <= 1'b0;
              state_r       <= ST_HOLD;
            end
          end
        end
        ST_ISSUE1: begin
          req_cmd_r  <= '0;
          req_data_r <= data2_r;
          state_r    <= ST_ISSUE2;
        end
        ST_ISSUE2: begin
          req_data_r <= '0;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          // A response on the timeout cycle takes priority over the timeout.
          if (resp_seen_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_code_r    <= out_resp;
            rsp_data_r    <= out_data;
            rsp_timeout_r <= 1'b0;
            state_r       <= ST_HOLD;
          end else if (timer_done_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_code_r    <= RESP_W'(RESP_NONE);
            rsp_data_r    <= '0;
            rsp_timeout_r <= 1'b1;
            state_r       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (rsp_ready) begin
            rsp_valid_r   <= 1'b0;
            rsp_code_r    <= '0;
            rsp_data_r    <= '0;
            rsp_timeout_r <= 1'b0;
            op_ready_r    <= 1'b1;
            state_r       <= ST_IDLE;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          op_ready_r    <= 1'b1;
          rsp_valid_r   <= 1'b0;
          rsp_code_r    <= '0;
          rsp_data_r    <= '0;
          rsp_timeout_r <= 1'b0;
          req_cmd_r     <= '0;
          req_data_r    <= '0;
        end
      endcase
    end
  end

  assign op_ready     = op_ready_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_code     = rsp_code_r;
  assign rsp_data     = rsp_data_r;
  assign rsp_timeout  = rsp_timeout_r;
  assign req_cmd_out  = req_cmd_r;
  assign req_data_out = req_data_r;
  assign spurious     = spurious_r;

endmodule
